// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - write/transmit handshake bundle for uart_tx_queue (UART_TXQ_DROP_CNT_EN adds clr_cnt/drop_cnt)
interface uart_tx_queue_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DBIT-1:0]   wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [DBIT-1:0]   din;
    logic              tx_start;
    logic              tx_done_tick;
    logic              busy;
`ifdef UART_TXQ_DROP_CNT_EN
    logic              clr_cnt;
    logic [7:0]        drop_cnt;

    modport slave (
        input  wr_en, wr_data, tx_done_tick, clr_cnt,
        output full, empty, level, overflow, din, tx_start, busy, drop_cnt
    );
    modport master (
        output wr_en, wr_data, tx_done_tick, clr_cnt,
        input  full, empty, level, overflow, din, tx_start, busy, drop_cnt
    );
`else
    modport slave (
        input  wr_en, wr_data, tx_done_tick,
        output full, empty, level, overflow, din, tx_start, busy
    );
    modport master (
        output wr_en, wr_data, tx_done_tick,
        input  full, empty, level, overflow, din, tx_start, busy
    );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and launch sequencer feeding the UART transmitter (optional UART_TXQ_DROP_CNT_EN)
module uart_tx_queue #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_queue_if.slave   bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_next;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic              r_tx_start;
    logic              r_busy;
    logic [DBIT-1:0]   r_din;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;

    // A write to a full queue is dropped outright, even if a pop frees a slot this cycle
    assign w_push = bus.wr_en && !r_full;
    assign w_drop = bus.wr_en && r_full;

    // Occupancy after this cycle's push and pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= bus.wr_data;
        end
    end

    // Pointers, count and the registered status flags derived from the next count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count    <= w_count_next;
            r_full     <= (w_count_next == C_DEPTH);
            r_empty    <= (w_count_next == '0);
            r_overflow <= w_drop;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and pop decision; tx_done_tick only matters while waiting
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT:   if (bus.tx_done_tick) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Registered transmitter-side outputs: din captured on pop, start pulse one cycle after LAUNCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_din      <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_pop) r_din <= r_mem[r_rptr];
            r_tx_start <= (r_state == S_LAUNCH);
            r_busy     <= (w_state_next != S_IDLE);
        end
    end

    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.level    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.din      = r_din;
    assign bus.tx_start = r_tx_start;
    assign bus.busy     = r_busy;

`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of dropped writes; clear wins over a same-cycle drop
    always_ff @(posedge clk) begin
        if (reset || bus.clr_cnt) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - directed self-checking bench for uart_tx_queue
module tb_uart_tx_queue;
    localparam int DBIT   = 8;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

    uart_tx_queue #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] data;
        logic       done;
        logic       e_empty;
        logic       e_full;
        logic [4:0] e_level;
        logic       e_txs;
        logic       e_busy;
        logic [7:0] e_din;
    } vec_t;

    vec_t       vq[$];
    int         checks = 0;
    int         errors = 0;
    int         n_start = 0;
    logic [7:0] seen[$];
    bit         auto_tx = 1'b0;
    int         tx_delay = 0;
    int         cd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rst, input logic wr, input logic [7:0] data, input logic done,
                           input logic e_empty, input logic e_full, input logic [4:0] e_level,
                           input logic e_txs, input logic e_busy, input logic [7:0] e_din);
        vec_t v;
        v.rst = rst; v.wr = wr; v.data = data; v.done = done;
        v.e_empty = e_empty; v.e_full = e_full; v.e_level = e_level;
        v.e_txs = e_txs; v.e_busy = e_busy; v.e_din = e_din;
        vq.push_back(v);
    endtask

    // One clock: sample after the edge, log launches, and drive the transmitter model
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.tx_start === 1'b1) begin
            n_start++;
            seen.push_back(bus.din);
            if (auto_tx) cd = tx_delay;
        end
        bus.tx_done_tick = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) bus.tx_done_tick = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_done_tick = 1'b0;
        auto_tx = 1'b0;
        cd = 0;
        repeat (3) tick();
        reset = 1'b0;
        seen.delete();
        n_start = 0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (!(bus.empty === 1'b1 && bus.busy === 1'b0 && cd == 0) && budget < 3000) begin
            tick();
            budget++;
        end
        chk({name, "_timeout"}, 32'(budget >= 3000), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_done_tick = 1'b0;
`ifdef UART_TXQ_DROP_CNT_EN
        bus.clr_cnt = 1'b0;
`endif

        // rst wr data done | empty full level txs busy din
        add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
        add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
        add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
        add_vec(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00);
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 8'hA5);
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5);
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 8'hA5);
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'hA5);
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'hA5);
        add_vec(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5);
        add_vec(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'hB1);
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'hB1);
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hB1);
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 8'hB2);
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 8'hB2);
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'hB2);

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst;
            bus.wr_en = vq[i].wr;
            bus.wr_data = vq[i].data;
            bus.tx_done_tick = vq[i].done;
            tick();
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty),    32'(vq[i].e_empty));
            chk($sformatf("vec%0d_full", i),  32'(bus.full),     32'(vq[i].e_full));
            chk($sformatf("vec%0d_level", i), 32'(bus.level),    32'(vq[i].e_level));
            chk($sformatf("vec%0d_txs", i),   32'(bus.tx_start), 32'(vq[i].e_txs));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),     32'(vq[i].e_busy));
            chk($sformatf("vec%0d_din", i),   32'(bus.din),      32'(vq[i].e_din));
        end
        bus.wr_en = 1'b0;

        // Single byte with a long transmitter frame
        do_reset();
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5; tick(); bus.wr_en = 1'b0;
        tick();
        tick();
        chk("single_txs", 32'(bus.tx_start), 32'd1);
        chk("single_din", 32'(bus.din), 32'hA5);
        tick();
        chk("single_txs_pulse", 32'(bus.tx_start), 32'd0);
        repeat (49) tick();
        chk("single_busy_wait", 32'(bus.busy), 32'd1);
        bus.tx_done_tick = 1'b1;
        tick();
        chk("single_busy_fall", 32'(bus.busy), 32'd0);

        // Burst ordering with a 20-cycle transmitter
        do_reset();
        auto_tx = 1'b1; tx_delay = 20;
        for (int k = 1; k <= 5; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(k); tick();
        end
        bus.wr_en = 1'b0;
        drain("burst");
        repeat (10) tick();
        chk("burst_starts", 32'(n_start), 32'd5);
        for (int k = 0; k < seen.size(); k++) chk($sformatf("burst_din%0d", k), 32'(seen[k]), 32'(k + 1));
        chk("burst_empty", 32'(bus.empty), 32'd1);

        // Full and overflow with the transmitter stalled
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h3F + k); tick();
            chk($sformatf("full_level%0d", k), 32'(bus.level), (k == 1) ? 32'd1 : ((k > 17) ? 32'd16 : 32'(k - 1)));
            chk($sformatf("full_ovf%0d", k), 32'(bus.overflow), 32'(k == 18));
        end
        bus.wr_en = 1'b0;
        chk("full_flag", 32'(bus.full), 32'd1);
        tick();
        chk("full_ovf_pulse_end", 32'(bus.overflow), 32'd0);
        chk("full_level_hold", 32'(bus.level), 32'd16);
`ifdef UART_TXQ_DROP_CNT_EN
        chk("drop_cnt_one", 32'(bus.drop_cnt), 32'd1);
        bus.clr_cnt = 1'b1; tick(); bus.clr_cnt = 1'b0;
        chk("drop_cnt_clr", 32'(bus.drop_cnt), 32'd0);
`endif
        auto_tx = 1'b1; tx_delay = 3;
        bus.tx_done_tick = 1'b1;
        tick();
        drain("full");
        chk("full_starts", 32'(n_start), 32'd17);
        for (int k = 0; k < seen.size(); k++) chk($sformatf("full_din%0d", k), 32'(seen[k]), 32'(8'h40 + k));

        // Simultaneous write/pop at level 15, wrapping the pointers
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(k); tick();
        end
        bus.wr_en = 1'b0;
        tick(); tick();
        chk("wrap_level_start", 32'(bus.level), 32'd15);
        for (int k = 16; k < 56; k++) begin
            bus.tx_done_tick = 1'b1; tick();
            bus.wr_en = 1'b1; bus.wr_data = 8'(k); tick(); bus.wr_en = 1'b0;
            chk($sformatf("wrap_level%0d", k), 32'(bus.level), 32'd15);
            tick();
        end
        auto_tx = 1'b1; tx_delay = 2;
        bus.tx_done_tick = 1'b1;
        tick();
        drain("wrap");
        chk("wrap_count", 32'(seen.size()), 32'd56);
        for (int k = 0; k < seen.size(); k++) chk($sformatf("wrap_din%0d", k), 32'(seen[k]), 32'(k));

        // Reset while waiting with three bytes queued
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'hC0 + k); tick();
        end
        bus.wr_en = 1'b0;
        tick(); tick();
        chk("rstw_level_before", 32'(bus.level), 32'd3);
        chk("rstw_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        n_start = 0;
        chk("rstw_level", 32'(bus.level), 32'd0);
        chk("rstw_empty", 32'(bus.empty), 32'd1);
        chk("rstw_busy", 32'(bus.busy), 32'd0);
        bus.tx_done_tick = 1'b1;
        tick();
        repeat (30) tick();
        chk("rstw_no_start", 32'(n_start), 32'd0);
        chk("rstw_busy_after", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
